// File: rtl/nco_sweep_ctrl.sv
// Steps an NCO phase increment through n_steps segments, waiting LAT settle cycles before each dwell window.
// Latency: every output is a flop, so an accepted start is visible one cycle later and the first seg_valid follows after LAT settle cycles.
// Backpressure: none. A start that arrives while a sweep is running is dropped, and abort always takes priority.
module nco_sweep_ctrl #(
  parameter int APR = 32,
  parameter int LAT = 6,
  parameter int NSW = 16,
  parameter int DWW = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic [APR-1:0] inc_start,
  input  logic [APR-1:0] inc_step,
  input  logic [NSW-1:0] n_steps,
  input  logic [DWW-1:0] dwell,
  output logic [APR-1:0] phi_inc_o,
  output logic           nco_clken,
  output logic           seg_valid,
  output logic [NSW-1:0] step_idx,
  output logic           busy,
  output logic           done
);

  // The settle and dwell phases share one down-counter. It must be wide enough for either load value.
  localparam int LAT_EFF = (LAT < 1) ? 1 : LAT;
  localparam int LW      = $clog2(LAT_EFF + 1);
  localparam int CW      = (DWW > LW) ? DWW : LW;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(LAT_EFF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [APR-1:0] phi_q, phi_d;
  logic [APR-1:0] step_q, step_d;
  logic [NSW-1:0] last_q, last_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NSW-1:0] idx_q, idx_d;
  logic           busy_q, busy_d;
  logic           clken_q, clken_d;
  logic           segv_q, segv_d;
  logic           done_q, done_d;

  // Next-state logic, including sweep parameter capture and the phase-increment step.
  // Status outputs are decoded from the next state, so they are aligned with state_q once registered.
  always_comb begin
    state_d = state_q;
    phi_d   = phi_q;
    step_d  = step_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          step_d  = inc_step;
          // A zero segment count or zero dwell is treated as one, so every sweep yields at least one valid cycle.
          last_d  = (n_steps == '0) ? '0 : n_steps - NSW'(1);
          dwell_d = (dwell == '0) ? DWW'(1) : dwell;
          phi_d   = inc_start;
          idx_d   = '0;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = CW'(dwell_q);
          state_d = DWELL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DWELL: begin
        if (cnt_q <= CW'(1)) begin
          if (idx_q == last_q) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            // The increment wraps modulo 2^APR; a negative step is applied as a two's-complement add.
            phi_d   = phi_q + step_q;
            idx_d   = idx_q + NSW'(1);
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      phi_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end

    busy_d  = (state_d == SETTLE) || (state_d == DWELL);
    clken_d = busy_d;
    segv_d  = (state_d == DWELL);
    done_d  = (state_d == DONE);
  end

  // State, datapath and output registers. All of them are cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phi_q   <= '0;
      step_q  <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      clken_q <= 1'b0;
      segv_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phi_q   <= phi_d;
      step_q  <= step_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      clken_q <= clken_d;
      segv_q  <= segv_d;
      done_q  <= done_d;
    end
  end

  assign phi_inc_o = phi_q;
  assign nco_clken = clken_q;
  assign seg_valid = segv_q;
  assign step_idx  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
module tb_nco_sweep_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [31:0] inc_start;
  logic [31:0] inc_step;
  logic [15:0] n_steps;
  logic [15:0] dwell;
  logic [31:0] phi_inc_o;
  logic        nco_clken;
  logic        seg_valid;
  logic [15:0] step_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int passes = 0;

  nco_sweep_ctrl #(.APR(32), .LAT(6), .NSW(16), .DWW(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .inc_start (inc_start),
    .inc_step  (inc_step),
    .n_steps   (n_steps),
    .dwell     (dwell),
    .phi_inc_o (phi_inc_o),
    .nco_clken (nco_clken),
    .seg_valid (seg_valid),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for a rising edge, then moves 1 time unit past it so outputs are sampled clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle with the given sweep parameters. On return the bench is observing cycle 1.
  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, input logic [15:0] w);
    inc_start = s;
    inc_step  = d;
    n_steps   = n;
    dwell     = w;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0;
    inc_start = 32'h0; inc_step = 32'h0; n_steps = 16'h0; dwell = 16'h0;
    repeat (3) tick();
    checks++;
    if ({busy, nco_clken, seg_valid, done, step_idx, phi_inc_o} !== 52'h0)
      $display("FAIL reset_state busy=%b clken=%b segv=%b done=%b idx=%0d phi=%h required all zero",
               busy, nco_clken, seg_valid, done, step_idx, phi_inc_o);
    else passes++;
    reset_n = 1'b1;
    tick();
  endtask

  // One segment, dwell 4: busy in cycles 1-10, seg_valid in 7-10, done only in cycle 11.
  task automatic test_single();
    logic [51:0] exp, obs;
    launch(32'h0100_0000, 32'h0, 16'd1, 16'd4);
    for (int c = 1; c <= 13; c++) begin
      exp = {(c <= 10), (c <= 10), (c >= 7 && c <= 10), (c == 11), 16'd0, 32'h0100_0000};
      obs = {busy, nco_clken, seg_valid, done, step_idx, phi_inc_o};
      checks++;
      if (obs !== exp) $display("FAIL single_seg cycle=%0d got=%h want=%h", c, obs, exp);
      else passes++;
      tick();
    end
  endtask

  // Three segments with the increment wrapping through zero. Each segment is 6 settle cycles plus 2 dwell cycles.
  task automatic test_wrap();
    logic [31:0] tbl [3];
    logic [51:0] exp, obs;
    int k, off;
    tbl[0] = 32'hFFFF_FFF0; tbl[1] = 32'h0000_0000; tbl[2] = 32'h0000_0010;
    launch(32'hFFFF_FFF0, 32'h0000_0010, 16'd3, 16'd2);
    for (int c = 1; c <= 26; c++) begin
      k   = (c <= 24) ? (c - 1) / 8 : 2;
      off = (c - 1) % 8;
      exp = {(c <= 24), (c <= 24), (c <= 24 && off >= 6), (c == 25), 16'(k), tbl[k]};
      obs = {busy, nco_clken, seg_valid, done, step_idx, phi_inc_o};
      checks++;
      if (obs !== exp) $display("FAIL wrap_sweep cycle=%0d got=%h want=%h", c, obs, exp);
      else passes++;
      tick();
    end
  endtask

  // A negative step of -128 with dwell 1: 0x100 in cycles 1-7, then 0x80 in cycles 8-14, then exactly one done pulse.
  task automatic test_negative_step();
    int ndone = 0, nvalid = 0;
    logic [31:0] exp_phi;
    launch(32'h0000_0100, 32'hFFFF_FF80, 16'd2, 16'd1);
    for (int c = 1; c <= 20; c++) begin
      if (done) ndone++;
      if (seg_valid) nvalid++;
      if (c == 7 || c == 14) begin
        exp_phi = (c == 7) ? 32'h100 : 32'h80;
        checks++;
        if (!(seg_valid === 1'b1 && phi_inc_o === exp_phi))
          $display("FAIL neg_step_dwell cycle=%0d segv=%b phi=%h want segv=1 phi=%h", c, seg_valid, phi_inc_o, exp_phi);
        else passes++;
      end
      if (c == 15) begin
        checks++;
        if (!(done === 1'b1 && busy === 1'b0 && phi_inc_o === 32'h80))
          $display("FAIL neg_step_done done=%b busy=%b phi=%h want done=1 busy=0 phi=00000080", done, busy, phi_inc_o);
        else passes++;
      end
      tick();
    end
    checks++;
    if (ndone !== 1 || nvalid !== 2)
      $display("FAIL neg_step_counts done_pulses=%0d valid_cycles=%0d want 1 and 2", ndone, nvalid);
    else passes++;
  endtask

  // A start pulsed during settle is dropped. Abort in the second dwell cycle of segment 1 returns straight to idle.
  // Abort asserted together with start in idle wins.
  task automatic test_abort();
    logic [51:0] exp, obs;
    logic        b, v;
    logic [31:0] p;
    logic [15:0] ix;
    int ndone = 0;
    launch(32'h0000_0200, 32'h0000_0040, 16'd3, 16'd3);
    for (int c = 1; c <= 23; c++) begin
      b  = (c <= 17);
      v  = (c >= 7 && c <= 9) || (c >= 16 && c <= 17);
      p  = (c > 17) ? 32'h0 : ((c <= 9) ? 32'h200 : 32'h240);
      ix = (c >= 10 && c <= 17) ? 16'd1 : 16'd0;
      exp = {b, b, v, 1'b0, ix, p};
      obs = {busy, nco_clken, seg_valid, done, step_idx, phi_inc_o};
      if (done) ndone++;
      checks++;
      if (obs !== exp) $display("FAIL abort_run cycle=%0d got=%h want=%h", c, obs, exp);
      else passes++;
      start = (c == 3) || (c == 20);
      abort = (c == 17) || (c == 20);
      inc_start = (c == 3 || c == 20) ? 32'hDEAD_0000 : 32'h0000_0200;
      tick();
    end
    start = 1'b0; abort = 1'b0;
    checks++;
    if (ndone !== 0) $display("FAIL abort_no_done done_pulses=%0d want 0", ndone);
    else passes++;
  endtask

  // Zero segment count and zero dwell each behave as one. Then reset is pulsed in the middle of settle.
  task automatic test_zero_and_reset();
    int nvalid = 0, ndone = 0;
    launch(32'h1234_5678, 32'h1, 16'd0, 16'd0);
    for (int c = 1; c <= 10; c++) begin
      if (seg_valid) nvalid++;
      if (c == 8) begin
        checks++;
        if (done !== 1'b1) $display("FAIL zero_done cycle=8 done=%b want 1", done);
        else passes++;
      end
      if (done) ndone++;
      tick();
    end
    checks++;
    if (nvalid !== 1 || ndone !== 1)
      $display("FAIL zero_counts valid_cycles=%0d done_pulses=%0d want 1 and 1", nvalid, ndone);
    else passes++;

    launch(32'h0BAD_F00D, 32'h1, 16'd2, 16'd2);
    tick(); tick();
    checks++;
    if (busy !== 1'b1 || seg_valid !== 1'b0)
      $display("FAIL pre_reset_settle busy=%b segv=%b want 1 and 0", busy, seg_valid);
    else passes++;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, nco_clken, seg_valid, done, step_idx, phi_inc_o} !== 52'h0)
      $display("FAIL async_reset busy=%b clken=%b segv=%b done=%b idx=%0d phi=%h required all zero",
               busy, nco_clken, seg_valid, done, step_idx, phi_inc_o);
    else passes++;
    reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) ndone++;
      tick();
    end
    checks++;
    if (ndone !== 0) $display("FAIL post_reset_quiet active_cycles=%0d want 0", ndone);
    else passes++;

    launch(32'h0000_0777, 32'h1, 16'd1, 16'd1);
    checks++;
    if (busy !== 1'b1 || phi_inc_o !== 32'h777)
      $display("FAIL restart_after_reset busy=%b phi=%h want busy=1 phi=00000777", busy, phi_inc_o);
    else passes++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || phi_inc_o !== 32'h0)
      $display("FAIL final_abort busy=%b phi=%h want 0 and 0", busy, phi_inc_o);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_negative_step();
    test_abort();
    test_zero_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
